add_rr_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined adder between two operand requesters (req0, req1).
- Grants at most one request per cycle and issues it into an internal ADD_LATENCY-stage adder pipeline.
- Returns each sum with its source ID through an output FIFO with valid/ready backpressure.
- Sits between the input-agent-facing ports and the output-agent-facing port of the add bench DUT.

---
 rtl/add_rr_sched.sv | 174 +++++++++++++++++
 tb/tb_add_rr_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_rr_sched.sv
// Round-robin scheduler sharing one pipelined adder between two requesters, with a credit-checked output FIFO.
// Optional build macro ADD_RR_SCHED_SAT_EN: saturate sums to 2^DATA_WIDTH-1 instead of keeping the carry bit.
module add_rr_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADD_LATENCY = 2,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH:0]   res_sum,
  output logic                  res_src,
  input  logic                  drain,
  output logic                  drain_done,
  output logic                  busy
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int INF_W = $clog2(ADD_LATENCY + 1);
  localparam int SUM_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    logic             src;
    logic [SUM_W-1:0] sum;
  } entry_t;

  state_t           state, state_nxt;
  logic             rr_ptr;        // 0: req0 wins a tie, 1: req1 wins
  logic             drain_armed;   // cleared after a drain completes until drain drops
  logic [CNT_W-1:0] fifo_count;
  logic [INF_W-1:0] inflight_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  entry_t           fifo_mem [OUT_DEPTH];

  logic [ADD_LATENCY-1:0] pipe_valid;
  entry_t                 pipe_data [ADD_LATENCY];

  logic                  credit_ok, grant_en, gnt0, gnt1, grant;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [SUM_W-1:0]      raw_sum, issue_sum;
  logic                  push, pop, pipe_empty, fifo_empty;
  entry_t                head;

  // Registered counts only, so a credit freed by a pop is reusable one cycle later.
  assign credit_ok = (int'(fifo_count) + int'(inflight_count)) < OUT_DEPTH;
  assign grant_en  = !rst && !drain && (state != DRAIN) && credit_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_en) begin
      if (req0_valid && req1_valid) begin
        gnt0 = !rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign grant      = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign op_a    = gnt1 ? req1_a : req0_a;
  assign op_b    = gnt1 ? req1_b : req0_b;
  assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADD_RR_SCHED_SAT_EN
  assign issue_sum = raw_sum[DATA_WIDTH] ? {1'b0, {DATA_WIDTH{1'b1}}} : raw_sum;
`else
  assign issue_sum = raw_sum;
`endif

  assign push       = pipe_valid[ADD_LATENCY-1];
  assign fifo_empty = (fifo_count == '0);
  assign pipe_empty = (inflight_count == '0);
  assign res_valid  = !fifo_empty;
  assign pop        = res_valid && res_ready;
  assign head       = fifo_mem[rd_ptr];
  assign res_sum    = res_valid ? head.sum : '0;
  assign res_src    = res_valid ? head.src : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= grant;
      for (int i = 1; i < ADD_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // NOTE: datapath and FIFO storage carry no reset; the valid bits and counts alone qualify them.
  always_ff @(posedge clk) begin
    if (grant) pipe_data[0] <= '{src: gnt1, sum: issue_sum};
    for (int i = 1; i < ADD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    if (push) fifo_mem[wr_ptr] <= pipe_data[ADD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      inflight_count <= '0;
      rr_ptr         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      case ({grant, push})
        2'b10:   inflight_count <= inflight_count + 1'b1;
        2'b01:   inflight_count <= inflight_count - 1'b1;
        default: inflight_count <= inflight_count;
      endcase
      if (grant) rr_ptr <= !gnt1;
    end
  end

  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (drain && drain_armed) state_nxt = DRAIN;
        else if (grant)           state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (drain)                                   state_nxt = DRAIN;
        else if (pipe_empty && fifo_empty && !grant) state_nxt = IDLE;
      end
      DRAIN: begin
        if (pipe_empty && fifo_empty) begin
          state_nxt  = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drain_armed <= 1'b1;
    end else begin
      state <= state_nxt;
      if (drain_done)  drain_armed <= 1'b0;
      else if (!drain) drain_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_add_rr_sched.sv
// Scoreboard bench for add_rr_sched: expected {src,sum} queued at each grant, compared at each result pop.
module tb_add_rr_sched;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          res_valid, res_ready, res_src;
  logic [DW:0]   res_sum;
  logic          drain, drain_done, busy;

  always #5 clk = ~clk;

  add_rr_sched #(.DATA_WIDTH(DW), .ADD_LATENCY(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_src(res_src),
    .drain(drain), .drain_done(drain_done), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  logic [DW+1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_RR_SCHED_SAT_EN
    if (s[DW]) s = {1'b0, {DW{1'b1}}};
`endif
    return s;
  endfunction

  // Scoreboard: push on each handshake, compare on each result pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, model_sum(req0_a, req0_b)});
        n_push++;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, model_sum(req1_a, req1_b)});
        n_push++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("sb_extra", 32'(res_valid), 32'd0);
        else begin
          check("sb_result", 32'({res_src, res_sum}), 32'(exp_q.pop_front()));
          n_pop++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain = 1'b0;
    res_ready = 1'b1;
    exp_q.delete();
    n_push = 0;
    n_pop = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || res_valid) && k < budget) begin
      step();
      k++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(n_pop), 32'(n_push));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic g0, g1, prev_pulse;
    int grants, more, pulses, rdy, k;
    logic [DW+1:0] head;

    rst = 1'b1; drain = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    reset_dut();

    // Single request: grant same cycle, result three cycles later.
    step();
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    @(negedge clk);
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_lat1", 32'(res_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_lat2", 32'(res_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_sum", 32'(res_sum), 32'h046);
    check("t1_src", 32'(res_src), 32'd0);
    wait_drained(20);

    // Contention: strict alternation starting with req0.
    reset_dut();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h01; req0_b = 8'h02; req1_a = 8'h10; req1_b = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      check("t2_one_ready", 32'(int'(g0) + int'(g1)), 32'd1);
      check("t2_order", 32'(g1), 32'(i % 2));
      step();
      if (g0) begin req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255)); end
      if (g1) begin req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drained(30);

    // Backpressure: credits limit grants to FIFO depth, head holds, then everything drains.
    reset_dut();
    res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    grants = 0; more = 0; head = '0;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) begin
        check("t3_grants", 32'(grants), 32'd4);
        check("t3_hold", 32'({res_src, res_sum}), 32'(head));
        check("t3_full_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
      end
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      if (i < 10) grants += int'(g0) + int'(g1);
      else more += int'(g0) + int'(g1);
      if (i == 6) head = {res_src, res_sum};
      step();
      if (g0) begin req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255)); end
      if (g1) begin req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255)); end
    end
    check("t3_resume", 32'(more > 4), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drained(40);

    // Carry / saturation.
    reset_dut();
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
    @(negedge clk);
    check("t4_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 10) begin step(); k++; end
`ifdef ADD_RR_SCHED_SAT_EN
    check("t4_sum", 32'(res_sum), 32'h0FF);
`else
    check("t4_sum", 32'(res_sum), 32'h100);
`endif
    check("t4_src", 32'(res_src), 32'd1);
    wait_drained(20);

    // Drain with two in flight and one queued.
    reset_dut();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_issue", 32'(req0_ready), 32'd1);
      step();
      req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
    end
    req1_valid = 1'b1; drain = 1'b1; res_ready = 1'b1;
    pulses = 0; rdy = 0; prev_pulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("t5_queued", 32'(res_valid), 32'd1);
      if (prev_pulse) check("t5_busy_after", 32'(busy), 32'd0);
      rdy += int'(req0_ready) + int'(req1_ready);
      pulses += int'(drain_done);
      prev_pulse = drain_done;
      step();
    end
    check("t5_no_ready", 32'(rdy), 32'd0);
    check("t5_pulses", 32'(pulses), 32'd1);
    drain = 1'b0;
    @(negedge clk);
    check("t5_resume", 32'(req1_ready), 32'd1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drained(20);

    // Mid-flight reset with three queued results.
    reset_dut();
    res_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
    end
    req0_valid = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check("t6_valid_pre", 32'(res_valid), 32'd1);
    step();
    rst = 1'b1;
    exp_q.delete();
    n_push = 0; n_pop = 0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_flush", 32'(res_valid), 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check("t6_no_stale", 32'(res_valid), 32'd0);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("t6_rr_req0", 32'(req0_ready), 32'd1);
    check("t6_rr_req1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drained(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
